// File: rtl/scoreboard_hazard_unit.sv
// scoreboard_hazard_unit
//   Per-register latency scoreboard for an in-order pipeline. Each
//   architectural register has a down-counter of the cycles left until its
//   pending result is produced. The ID-stage instruction is stalled on a
//   read-after-write hazard when a source still needs more than one cycle.
//   A count of exactly 1 means the result will be on the forwarding path in
//   time. The instruction is also stalled on a write-after-write hazard when
//   an older write to the same destination would finish after the new one.
//
// Ports
//   clk, rst                 clock, asynchronous active-low reset
//   issue_valid              ID stage holds a valid instruction
//   issue_rs/rt, rs/rt_used  source addresses and their read enables
//   issue_rd, issue_wr       destination address and its write enable
//   issue_lat                cycles until the result is forwardable (1..MAX_LAT)
//   flush                    squash the ID instruction this cycle
//   freeze                   external pipeline hold
//   stall                    hold IF/ID and PC, inject a bubble (combinational)
//   pc_write, if_id_write    ~stall (combinational)
//   bubble                   zero the ID/EX control word (combinational)
//   stall_count              saturating count of stalled cycles (registered)
//   lat_error                sticky illegal-latency flag (registered)
//
// Handshake: an instruction is accepted in the cycle where issue_valid=1,
// stall=0 and flush=0. Only an accepted instruction updates the scoreboard.
module scoreboard_hazard_unit #(
  parameter int REG_COUNT = 32,
  parameter int ADDR_W    = 5,
  parameter int MAX_LAT   = 4,
  parameter int LAT_W     = 4,
  parameter int CNT_W     = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              issue_valid,
  input  logic [ADDR_W-1:0] issue_rs,
  input  logic [ADDR_W-1:0] issue_rt,
  input  logic              rs_used,
  input  logic              rt_used,
  input  logic [ADDR_W-1:0] issue_rd,
  input  logic              issue_wr,
  input  logic [LAT_W-1:0]  issue_lat,
  input  logic              flush,
  input  logic              freeze,
  output logic              stall,
  output logic              pc_write,
  output logic              if_id_write,
  output logic              bubble,
  output logic [CNT_W-1:0]  stall_count,
  output logic              lat_error
);

  localparam logic [LAT_W-1:0] MAX_LAT_V = LAT_W'(MAX_LAT);
  localparam logic [LAT_W-1:0] ONE_V     = LAT_W'(1);

  // Register 0 is hard-wired, so storage starts at index 1.
  logic [LAT_W-1:0] cnt_q [REG_COUNT-1:1];
  logic [LAT_W-1:0] cnt_d [REG_COUNT-1:1];
  logic [LAT_W-1:0] cnt_view [REG_COUNT];

  logic [CNT_W-1:0] stall_count_q, stall_count_d;
  logic             lat_error_q, lat_error_d;

  logic [LAT_W-1:0] rs_cnt, rt_cnt, rd_cnt;
  logic             raw_haz, waw_haz, accept, lat_bad;
  logic [LAT_W-1:0] load_lat;

  always_comb begin
    cnt_view[0] = '0;
    for (int r = 1; r < REG_COUNT; r++) begin
      cnt_view[r] = cnt_q[r];
    end
  end

  assign rs_cnt = cnt_view[issue_rs];
  assign rt_cnt = cnt_view[issue_rt];
  assign rd_cnt = cnt_view[issue_rd];

  // A source with count 1 reaches the forwarding path in time, so only
  // counts above 1 block the reader.
  assign raw_haz = issue_valid & ((rs_used & (rs_cnt > ONE_V)) |
                                  (rt_used & (rt_cnt > ONE_V)));
  // Keep completions in order: an older write must not land after this one.
  assign waw_haz = issue_valid & issue_wr & (issue_rd != '0) &
                   (rd_cnt > issue_lat);

  // Counters are cleared asynchronously, so during reset the hazard terms
  // are already zero and stall follows freeze alone.
  assign stall       = freeze | ((raw_haz | waw_haz) & ~flush);
  assign pc_write    = ~stall;
  assign if_id_write = ~stall;
  assign bubble      = stall | (issue_valid & flush);
  assign accept      = issue_valid & ~stall & ~flush;

  assign lat_bad  = (issue_lat == '0) | (issue_lat > MAX_LAT_V);
  assign load_lat = lat_bad ? MAX_LAT_V : issue_lat;

  always_comb begin
    for (int r = 1; r < REG_COUNT; r++) begin
      cnt_d[r] = cnt_q[r];
      if (!freeze && (cnt_q[r] != '0)) begin
        cnt_d[r] = cnt_q[r] - ONE_V;
      end
      // A new load overrides the decrement of the same register.
      if (accept && issue_wr && (issue_rd == ADDR_W'(r))) begin
        cnt_d[r] = load_lat;
      end
    end
  end

  always_comb begin
    stall_count_d = stall_count_q;
    if (stall && (stall_count_q != '1)) begin
      stall_count_d = stall_count_q + CNT_W'(1);
    end
  end

  assign lat_error_d = lat_error_q | (accept & issue_wr & lat_bad);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int r = 1; r < REG_COUNT; r++) begin
        cnt_q[r] <= '0;
      end
      stall_count_q <= '0;
      lat_error_q   <= 1'b0;
    end else begin
      for (int r = 1; r < REG_COUNT; r++) begin
        cnt_q[r] <= cnt_d[r];
      end
      stall_count_q <= stall_count_d;
      lat_error_q   <= lat_error_d;
    end
  end

  assign stall_count = stall_count_q;
  assign lat_error   = lat_error_q;

endmodule
